// File: rtl/combo_lock_pkg.sv
// -----------------------------------------------------------------------------
// combo_lock_pkg
// Shared definitions for the combination-lock datapath.
//   state_t       : FSM state / HEX message code, fixed 3-bit encodings that the
//                   checker FSM and the HEX message encoder also decode.
//   DIGIT_MAX     : largest legal BCD digit.
//   is_bcd_digit  : helper that qualifies a nibble as a legal decimal digit.
// -----------------------------------------------------------------------------
package combo_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTER1 = 3'd1,
        ST_ENTER2 = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/combo_digit_shifter.sv
// -----------------------------------------------------------------------------
// combo_digit_shifter
// First-pass buffer for the code programmer plus the second-pass compare.
// Digits shift in at the LSB end, so after DIGITS shifts the first-entered
// digit sits in the most significant nibble, matching the code_out layout.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset, clears the buffer
//   clear      : synchronous clear (programming (re)start)
//   shift_en   : shift digit_in into the buffer this cycle
//   digit_in   : BCD digit
//   sel_index  : digit position of the current second-pass digit (0 = first)
//   buffer     : full buffer contents
//   match      : digit_in equals the buffered digit at sel_index
// -----------------------------------------------------------------------------
module combo_digit_shifter #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [3:0]            digit_in,
    input  logic [2:0]            sel_index,
    output logic [DIGITS*4-1:0]   buffer,
    output logic                  match
);

    logic [DIGITS*4-1:0] buffer_r;
    logic [3:0]          sel_nibble_s;

    // Buffer register: left shift by one nibble per accepted first-pass digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer_r <= {(DIGITS*4){1'b0}};
        end else if (clear) begin
            buffer_r <= {(DIGITS*4){1'b0}};
        end else if (shift_en) begin
            buffer_r <= {buffer_r[DIGITS*4-5:0], digit_in};
        end else begin
            buffer_r <= buffer_r;
        end
    end

    // Nibble select: position i of the entry lives at nibble DIGITS-1-i.
    always_comb begin
        sel_nibble_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_index == 3'(i)) begin
                sel_nibble_s = buffer_r[4*(DIGITS-1-i) +: 4];
            end else begin
                sel_nibble_s = sel_nibble_s;
            end
        end
    end

    // Compare of the incoming digit against the selected buffered digit.
    always_comb begin
        match = (sel_nibble_s == digit_in);
    end

    assign buffer = buffer_r;

endmodule

// File: rtl/combo_code_programmer.sv
// -----------------------------------------------------------------------------
// combo_code_programmer
// Writer side of the combination lock: the user enters a new DIGITS-digit code
// twice and it is committed to code_out only if both entries agree.
// Ports:
//   clk          : system clock, all state changes on the rising edge
//   reset        : synchronous active-high reset (priority over all inputs)
//   start        : one-cycle pulse, begin or restart programming
//   digit_valid  : one-cycle pulse, digit_in is sampled this cycle
//   digit_in     : BCD digit, legal values 0-9
//   code_out     : committed combination, first-entered digit in the MS nibble
//   commit       : one-cycle pulse while code_out shows a newly committed code
//   busy         : high in ENTER1 or ENTER2
//   error        : high in ERR
//   digit_count  : digits accepted in the current entry pass
//   status       : HEX message code (0 IDLE, 1 ENTER1, 2 ENTER2, 3 DONE, 4 ERR)
// -----------------------------------------------------------------------------
module combo_code_programmer
    import combo_lock_pkg::*;
#(
    parameter int                    DIGITS     = 6,
    parameter logic [DIGITS*4-1:0]   RESET_CODE = 24'h305464
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  digit_valid,
    input  logic [3:0]            digit_in,
    output logic [DIGITS*4-1:0]   code_out,
    output logic                  commit,
    output logic                  busy,
    output logic                  error,
    output logic [2:0]            digit_count,
    output logic [2:0]            status
);

    localparam logic [2:0] LAST_INDEX = 3'(DIGITS - 1);

    state_t              state_r;
    logic [2:0]          status_r;
    logic [DIGITS*4-1:0] code_r;
    logic                commit_r;
    logic [2:0]          count_r;
    logic                mismatch_r;

    logic                digit_legal_s;
    logic                last_digit_s;
    logic                mismatch_next_s;
    logic                shift_en_s;
    logic                clear_s;
    logic                match_s;
    logic [DIGITS*4-1:0] buffer_s;
    logic                busy_s;
    logic                error_s;

    // Input qualification shared by the FSM and the shifter. start always wins
    // over a simultaneous digit, so a digit is only shifted when start is low.
    always_comb begin
        digit_legal_s   = is_bcd_digit(digit_in);
        last_digit_s    = (count_r == LAST_INDEX);
        mismatch_next_s = mismatch_r | ~match_s;
        shift_en_s      = (state_r == ST_ENTER1) && digit_valid && !start && digit_legal_s;
        clear_s         = start && (state_r != ST_DONE);
    end

    combo_digit_shifter #(
        .DIGITS (DIGITS)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .shift_en  (shift_en_s),
        .digit_in  (digit_in),
        .sel_index (count_r),
        .buffer    (buffer_s),
        .match     (match_s)
    );

    // Programming FSM with the committed-code register and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            status_r   <= ST_IDLE;
            code_r     <= RESET_CODE;
            commit_r   <= 1'b0;
            count_r    <= 3'd0;
            mismatch_r <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_ENTER1;
                        status_r   <= ST_ENTER1;
                        count_r    <= 3'd0;
                        mismatch_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_ENTER1: begin
                    if (start) begin
                        state_r    <= ST_ENTER1;
                        status_r   <= ST_ENTER1;
                        count_r    <= 3'd0;
                        mismatch_r <= 1'b0;
                    end else if (digit_valid) begin
                        if (!digit_legal_s) begin
                            state_r  <= ST_ERR;
                            status_r <= ST_ERR;
                            count_r  <= 3'd0;
                        end else if (last_digit_s) begin
                            state_r    <= ST_ENTER2;
                            status_r   <= ST_ENTER2;
                            count_r    <= 3'd0;
                            mismatch_r <= 1'b0;
                        end else begin
                            count_r <= count_r + 3'd1;
                        end
                    end else begin
                        state_r <= ST_ENTER1;
                    end
                end

                ST_ENTER2: begin
                    if (start) begin
                        state_r    <= ST_ENTER1;
                        status_r   <= ST_ENTER1;
                        count_r    <= 3'd0;
                        mismatch_r <= 1'b0;
                    end else if (digit_valid) begin
                        if (!digit_legal_s) begin
                            state_r  <= ST_ERR;
                            status_r <= ST_ERR;
                            count_r  <= 3'd0;
                        end else if (last_digit_s) begin
                            // Verdict only on the final digit, so the position
                            // of a wrong digit is never revealed.
                            count_r    <= 3'd0;
                            mismatch_r <= 1'b0;
                            if (mismatch_next_s) begin
                                state_r  <= ST_ERR;
                                status_r <= ST_ERR;
                            end else begin
                                state_r  <= ST_DONE;
                                status_r <= ST_DONE;
                                code_r   <= buffer_s;
                                commit_r <= 1'b1;
                            end
                        end else begin
                            count_r    <= count_r + 3'd1;
                            mismatch_r <= mismatch_next_s;
                        end
                    end else begin
                        state_r <= ST_ENTER2;
                    end
                end

                ST_DONE: begin
                    // status keeps showing DONE while idling until next start.
                    state_r <= ST_IDLE;
                    count_r <= 3'd0;
                end

                ST_ERR: begin
                    if (start) begin
                        state_r    <= ST_ENTER1;
                        status_r   <= ST_ENTER1;
                        count_r    <= 3'd0;
                        mismatch_r <= 1'b0;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    status_r   <= ST_IDLE;
                    count_r    <= 3'd0;
                    mismatch_r <= 1'b0;
                end
            endcase
        end
    end

    // busy/error decode from the registered state only, no input paths.
    always_comb begin
        busy_s  = (state_r == ST_ENTER1) || (state_r == ST_ENTER2);
        error_s = (state_r == ST_ERR);
    end

    assign code_out    = code_r;
    assign commit      = commit_r;
    assign busy        = busy_s;
    assign error       = error_s;
    assign digit_count = count_r;
    assign status      = status_r;

endmodule
